// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding, PSDIR encoding and sizing helper for the PLL phase-shift sequencer.
package pll_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_RST_HOLD  = 3'd0;
  localparam state_t S_WAIT_LOCK = 3'd1;
  localparam state_t S_IDLE      = 3'd2;
  localparam state_t S_SETUP     = 3'd3;
  localparam state_t S_PULSE_HI  = 3'd4;
  localparam state_t S_PULSE_LO  = 3'd5;
  localparam state_t S_DONE      = 3'd6;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  // Bits needed to hold values 0..v-1; never less than one bit.
  function automatic int clog2(input int unsigned v);
    int          r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a slow asynchronous level, cleared by the async active-low reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_phase_ctrl.sv
// PLL power-up reset, lock supervision and dynamic phase-shift sequencer on the 50 MHz reference.
// Build option PLL_AUTO_RELOCK_EN: on lock loss abort the request, re-reset the PLL and clear positions.
//
// state       | meaning
// RST_HOLD    | pll_reset asserted for RST_CYCLES
// WAIT_LOCK   | pll_reset released, waiting for synced lock or timeout
// IDLE        | locked, cmd_ready high
// SETUP       | pssel/psdir settling before the first pulse
// PULSE_HI    | pll_pspulse high
// PULSE_LO    | gap after a pulse; position updated on exit
// DONE        | one-cycle completion strobe
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH        = 7,
  parameter int unsigned STEPS_PER_CYC = 8,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned SETUP_CYCLES  = 4,
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned GAP_CYCLES    = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   pll_lock,
  output logic                                   pll_reset,
  output logic [2:0]                             pll_pssel,
  output logic                                   pll_psdir,
  output logic                                   pll_pspulse,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [2:0]                             cmd_ch,
  input  logic [3:0]                             cmd_steps,
  input  logic                                   cmd_dir,
  output logic                                   done,
  output logic                                   locked,
  output logic                                   lock_lost,
  output logic [NUM_CH*clog2(STEPS_PER_CYC)-1:0] ch_pos
);

  localparam int PW = clog2(STEPS_PER_CYC);
  localparam int CW = clog2(LOCK_TIMEOUT + 1);

  localparam logic [CW-1:0] LD_RST   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LD_LOCK  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] LD_GAP   = CW'(GAP_CYCLES - 1);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [3:0]      rem;
  logic [PW-1:0]   pos [NUM_CH];
  logic            lock_s;
  logic            tc;
  logic            op_state;
  logic            lock_drop;
  logic            start;
  logic            step_done;

  sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign tc        = (cnt == '0);
  assign op_state  = (state >= S_IDLE) && (state <= S_DONE);
  assign lock_drop = op_state && !lock_s;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = tc ? cnt : cnt - 1'b1;
    start     = 1'b0;
    step_done = 1'b0;
    case (state)
      S_RST_HOLD: begin
        if (tc) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = LD_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = S_IDLE;
        end else if (tc) begin
          state_nxt = S_RST_HOLD;
          cnt_nxt   = LD_RST;
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_steps == '0 || 32'(cmd_ch) >= NUM_CH) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_SETUP;
            cnt_nxt   = LD_SETUP;
            start     = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (tc) begin
          state_nxt = S_PULSE_HI;
          cnt_nxt   = LD_PULSE;
        end
      end
      S_PULSE_HI: begin
        if (tc) begin
          state_nxt = S_PULSE_LO;
          cnt_nxt   = LD_GAP;
        end
      end
      S_PULSE_LO: begin
        if (tc) begin
          step_done = 1'b1;
          if (rem == 4'd1) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_PULSE_HI;
            cnt_nxt   = LD_PULSE;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_RST_HOLD;
        cnt_nxt   = LD_RST;
      end
    endcase
`ifdef PLL_AUTO_RELOCK_EN
    if (lock_drop) begin
      state_nxt = S_RST_HOLD;
      cnt_nxt   = LD_RST;
      start     = 1'b0;
      step_done = 1'b0;
    end
`endif
  end

  // PLL-facing strobes are registered from the next state so they never glitch on state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RST_HOLD;
      cnt         <= LD_RST;
      pll_reset   <= 1'b1;
      pll_pspulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pll_reset   <= (state_nxt == S_RST_HOLD);
      pll_pspulse <= (state_nxt == S_PULSE_HI);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_pssel <= '0;
      pll_psdir <= DIR_INC;
      rem       <= '0;
      lock_lost <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) pos[i] <= '0;
    end else begin
      if (start) begin
        pll_pssel <= cmd_ch;
        pll_psdir <= cmd_dir;
        rem       <= cmd_steps;
      end
      if (step_done) begin
        rem <= rem - 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (int'(pll_pssel) == i) begin
            pos[i] <= (pll_psdir == DIR_DEC) ? pos[i] - 1'b1 : pos[i] + 1'b1;
          end
        end
      end
      // Every PLL reset reverts the hardware phase settings, so the tracked positions follow.
      if (state_nxt == S_RST_HOLD) begin
        for (int i = 0; i < NUM_CH; i++) pos[i] <= '0;
      end
      if (lock_drop) lock_lost <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pos
    assign ch_pos[g*PW +: PW] = pos[g];
  end

  assign cmd_ready = (state == S_IDLE);
  assign locked    = op_state && lock_s;
`ifdef PLL_AUTO_RELOCK_EN
  assign done      = (state == S_DONE) && lock_s;
`else
  assign done      = (state == S_DONE);
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: reset, lock timeout, lock acquire, phase requests, lock loss, async reset.
module tb_pll_phase_ctrl;

  logic        clk;
  logic        rst_n;
  logic        pll_lock;
  logic        pll_reset;
  logic [2:0]  pll_pssel;
  logic        pll_psdir;
  logic        pll_pspulse;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_ch;
  logic [3:0]  cmd_steps;
  logic        cmd_dir;
  logic        done;
  logic        locked;
  logic        lock_lost;
  logic [20:0] ch_pos;

  int   nvec;
  int   nerr;
  logic lock_en;
  logic force_unlock;
  int   lcnt;
  logic obs [0:200];

  pll_phase_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .pll_reset   (pll_reset),
    .pll_pssel   (pll_pssel),
    .pll_psdir   (pll_psdir),
    .pll_pspulse (pll_pspulse),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_ch      (cmd_ch),
    .cmd_steps   (cmd_steps),
    .cmd_dir     (cmd_dir),
    .done        (done),
    .locked      (locked),
    .lock_lost   (lock_lost),
    .ch_pos      (ch_pos)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // PLL model: lock rises 100 clocks after pll_reset falls, drops while held in reset or forced.
  initial begin
    pll_lock = 1'b0;
    lcnt     = 0;
    forever begin
      @(negedge clk);
      if (pll_reset === 1'b1 || !lock_en) begin
        lcnt     = 0;
        pll_lock = 1'b0;
      end else begin
        if (lcnt < 100) lcnt++;
        pll_lock = (lcnt >= 100) && !force_unlock;
      end
    end
  end

  task automatic do_req(input logic [2:0] ch, input logic [3:0] steps, input logic dir, input int drop_k,
                        output int done_k, output int npulse, output int sel_bad, output int rdy_busy,
                        output logic done_after, output logic saw_reset);
    logic prev;
    done_k = -1; npulse = 0; sel_bad = 0; rdy_busy = 0; done_after = 1'b0; saw_reset = 1'b0; prev = 1'b0;
    for (int i = 0; i <= 200; i++) obs[i] = 1'b0;
    for (int i = 0; i < 300 && cmd_ready !== 1'b1; i++) @(negedge clk);
    cmd_ch = ch; cmd_steps = steps; cmd_dir = dir; cmd_valid = 1'b1;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      obs[k] = pll_pspulse;
      if (pll_pspulse && !prev) npulse++;
      prev = pll_pspulse;
      if (pll_pspulse && (pll_pssel !== ch || pll_psdir !== dir)) sel_bad++;
      if (pll_reset === 1'b1) saw_reset = 1'b1;
      if (done_k < 0 && cmd_ready === 1'b1) rdy_busy++;
      if (k == drop_k) force_unlock = 1'b1;
      if (done_k > 0 && k == done_k + 1) begin
        done_after = done;
        break;
      end
      if (done === 1'b1 && done_k < 0) done_k = k;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nvec++; if (pll_reset !== 1'b1) begin nerr++; $display("FAIL rst_pll_reset got %b want 1", pll_reset); end
    nvec++; if (pll_pssel !== 3'd0) begin nerr++; $display("FAIL rst_pssel got %0d want 0", pll_pssel); end
    nvec++; if (pll_psdir !== 1'b0) begin nerr++; $display("FAIL rst_psdir got %b want 0", pll_psdir); end
    nvec++; if (pll_pspulse !== 1'b0) begin nerr++; $display("FAIL rst_pspulse got %b want 0", pll_pspulse); end
    nvec++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done got %b want 0", done); end
    nvec++; if (locked !== 1'b0) begin nerr++; $display("FAIL rst_locked got %b want 0", locked); end
    nvec++; if (lock_lost !== 1'b0) begin nerr++; $display("FAIL rst_lock_lost got %b want 0", lock_lost); end
    nvec++; if (ch_pos !== 21'h0) begin nerr++; $display("FAIL rst_ch_pos got %h want 0", ch_pos); end
  endtask

  task automatic test_lock_timeout();
    int   fall1, rise1, fall2;
    logic prev, lk_seen;
    fall1 = -1; rise1 = -1; fall2 = -1; prev = 1'b1; lk_seen = 1'b0;
    lock_en = 1'b0;
    rst_n = 1'b1;
    for (int k = 1; k <= 65600; k++) begin
      @(negedge clk);
      if (locked === 1'b1) lk_seen = 1'b1;
      if (prev && pll_reset === 1'b0) begin
        if (fall1 < 0) fall1 = k; else if (fall2 < 0) fall2 = k;
      end
      if (!prev && pll_reset === 1'b1 && rise1 < 0) rise1 = k;
      prev = pll_reset;
    end
    nvec++; if (fall1 !== 16) begin nerr++; $display("FAIL to_first_release got %0d want 16", fall1); end
    nvec++; if (rise1 !== 65551) begin nerr++; $display("FAIL to_retry_reset got %0d want 65551", rise1); end
    nvec++; if (fall2 !== 65567) begin nerr++; $display("FAIL to_retry_release got %0d want 65567", fall2); end
    nvec++; if (lk_seen !== 1'b0) begin nerr++; $display("FAIL to_locked got %b want 0", lk_seen); end
  endtask

  task automatic test_lock_acquire();
    int   fall;
    logic lk116, lk119, rdy119;
    fall = -1; lk116 = 1'bx; lk119 = 1'bx; rdy119 = 1'bx;
    rst_n = 1'b0;
    lock_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      if (fall < 0 && pll_reset === 1'b0) fall = k;
      if (k == 116) lk116 = locked;
      if (k == 119) begin lk119 = locked; rdy119 = cmd_ready; end
    end
    nvec++; if (fall !== 16) begin nerr++; $display("FAIL acq_reset_width got %0d want 16", fall); end
    nvec++; if (lk116 !== 1'b0) begin nerr++; $display("FAIL acq_locked_early got %b want 0", lk116); end
    nvec++; if (lk119 !== 1'b1) begin nerr++; $display("FAIL acq_locked got %b want 1", lk119); end
    nvec++; if (rdy119 !== 1'b1) begin nerr++; $display("FAIL acq_cmd_ready got %b want 1", rdy119); end
  endtask

  task automatic test_shift_inc();
    int dk, np, sb, rb, mism;
    logic da, sr, e;
    do_req(3'd1, 4'd3, 1'b0, -1, dk, np, sb, rb, da, sr);
    mism = 0;
    for (int k = 1; k <= 24; k++) begin
      e = (k >= 5) && (k < 23) && (((k - 5) % 6) < 2);
      if (obs[k] !== e) mism++;
    end
    nvec++; if (dk !== 23) begin nerr++; $display("FAIL inc_done_latency got %0d want 23", dk); end
    nvec++; if (np !== 3) begin nerr++; $display("FAIL inc_pulses got %0d want 3", np); end
    nvec++; if (mism !== 0) begin nerr++; $display("FAIL inc_pulse_shape got %0d bad cycles want 0", mism); end
    nvec++; if (sb !== 0) begin nerr++; $display("FAIL inc_sel_during_pulse got %0d want 0", sb); end
    nvec++; if (rb !== 0) begin nerr++; $display("FAIL inc_ready_busy got %0d want 0", rb); end
    nvec++; if (da !== 1'b0) begin nerr++; $display("FAIL inc_done_width got %b want 0", da); end
    nvec++; if (ch_pos !== 21'h18) begin nerr++; $display("FAIL inc_ch_pos got %h want 18", ch_pos); end
  endtask

  task automatic test_shift_dec_wrap();
    int dk, np, sb, rb, mism;
    logic da, sr, e;
    do_req(3'd1, 4'd5, 1'b1, -1, dk, np, sb, rb, da, sr);
    mism = 0;
    for (int k = 1; k <= 36; k++) begin
      e = (k >= 5) && (k < 35) && (((k - 5) % 6) < 2);
      if (obs[k] !== e) mism++;
    end
    nvec++; if (dk !== 35) begin nerr++; $display("FAIL dec_done_latency got %0d want 35", dk); end
    nvec++; if (np !== 5) begin nerr++; $display("FAIL dec_pulses got %0d want 5", np); end
    nvec++; if (mism !== 0) begin nerr++; $display("FAIL dec_pulse_shape got %0d bad cycles want 0", mism); end
    nvec++; if (sb !== 0) begin nerr++; $display("FAIL dec_sel_during_pulse got %0d want 0", sb); end
    nvec++; if (ch_pos !== 21'h30) begin nerr++; $display("FAIL dec_ch_pos got %h want 30", ch_pos); end
  endtask

  task automatic test_no_pulse();
    int dk, np, sb, rb;
    logic da, sr;
    do_req(3'd2, 4'd0, 1'b0, -1, dk, np, sb, rb, da, sr);
    nvec++; if (dk !== 1) begin nerr++; $display("FAIL zero_done got %0d want 1", dk); end
    nvec++; if (np !== 0) begin nerr++; $display("FAIL zero_pulses got %0d want 0", np); end
    nvec++; if (ch_pos !== 21'h30) begin nerr++; $display("FAIL zero_ch_pos got %h want 30", ch_pos); end
    do_req(3'd7, 4'd3, 1'b0, -1, dk, np, sb, rb, da, sr);
    nvec++; if (dk !== 1) begin nerr++; $display("FAIL badch_done got %0d want 1", dk); end
    nvec++; if (np !== 0) begin nerr++; $display("FAIL badch_pulses got %0d want 0", np); end
    nvec++; if (ch_pos !== 21'h30) begin nerr++; $display("FAIL badch_ch_pos got %h want 30", ch_pos); end
    nvec++; if (pll_pssel !== 3'd1) begin nerr++; $display("FAIL badch_pssel_hold got %0d want 1", pll_pssel); end
  endtask

  task automatic test_back_to_back();
    int dk, np, sb, rb;
    logic da, sr;
    do_req(3'd0, 4'd1, 1'b0, -1, dk, np, sb, rb, da, sr);
    nvec++; if (dk !== 11) begin nerr++; $display("FAIL b2b_first_done got %0d want 11", dk); end
    do_req(3'd0, 4'd2, 1'b0, -1, dk, np, sb, rb, da, sr);
    nvec++; if (dk !== 17) begin nerr++; $display("FAIL b2b_second_done got %0d want 17", dk); end
    nvec++; if (np !== 2) begin nerr++; $display("FAIL b2b_pulses got %0d want 2", np); end
    nvec++; if (ch_pos !== 21'h33) begin nerr++; $display("FAIL b2b_ch_pos got %h want 33", ch_pos); end
  endtask

  task automatic test_lock_drop();
    int dk, np, sb, rb, w;
    logic da, sr;
    do_req(3'd2, 4'd4, 1'b0, 10, dk, np, sb, rb, da, sr);
    nvec++; if (lock_lost !== 1'b1) begin nerr++; $display("FAIL drop_lock_lost got %b want 1", lock_lost); end
    nvec++; if (locked !== 1'b0) begin nerr++; $display("FAIL drop_locked got %b want 0", locked); end
`ifdef PLL_AUTO_RELOCK_EN
    nvec++; if (dk !== -1) begin nerr++; $display("FAIL drop_no_done got %0d want -1", dk); end
    nvec++; if (sr !== 1'b1) begin nerr++; $display("FAIL drop_rst_hold got %b want 1", sr); end
    nvec++; if (ch_pos !== 21'h0) begin nerr++; $display("FAIL drop_ch_pos got %h want 0", ch_pos); end
`else
    nvec++; if (dk !== 29) begin nerr++; $display("FAIL drop_done got %0d want 29", dk); end
    nvec++; if (np !== 4) begin nerr++; $display("FAIL drop_pulses got %0d want 4", np); end
    nvec++; if (ch_pos !== 21'h133) begin nerr++; $display("FAIL drop_ch_pos got %h want 133", ch_pos); end
`endif
    force_unlock = 1'b0;
    w = 0;
    while (locked !== 1'b1 && w < 300) begin @(negedge clk); w++; end
    nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL relock got %b want 1", locked); end
    nvec++; if (lock_lost !== 1'b1) begin nerr++; $display("FAIL sticky_lock_lost got %b want 1", lock_lost); end
  endtask

  task automatic test_async_reset();
    logic hi;
    hi = 1'b0;
    for (int i = 0; i < 300 && cmd_ready !== 1'b1; i++) @(negedge clk);
    cmd_ch = 3'd0; cmd_steps = 4'd2; cmd_dir = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !hi; i++) begin
      if (pll_pspulse === 1'b1) hi = 1'b1; else @(negedge clk);
    end
    nvec++; if (hi !== 1'b1) begin nerr++; $display("FAIL ar_pulse_seen got %b want 1", hi); end
    #3 rst_n = 1'b0;
    #1;
    nvec++; if (pll_pspulse !== 1'b0) begin nerr++; $display("FAIL ar_pspulse got %b want 0", pll_pspulse); end
    nvec++; if (pll_reset !== 1'b1) begin nerr++; $display("FAIL ar_pll_reset got %b want 1", pll_reset); end
    nvec++; if (ch_pos !== 21'h0) begin nerr++; $display("FAIL ar_ch_pos got %h want 0", ch_pos); end
    nvec++; if (lock_lost !== 1'b0) begin nerr++; $display("FAIL ar_lock_lost got %b want 0", lock_lost); end
    nvec++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL ar_cmd_ready got %b want 0", cmd_ready); end
    nvec++; if (pll_pssel !== 3'd0) begin nerr++; $display("FAIL ar_pssel got %0d want 0", pll_pssel); end
  endtask

  initial begin
    nvec = 0; nerr = 0;
    lock_en = 1'b0; force_unlock = 1'b0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_ch = 3'd0; cmd_steps = 4'd0; cmd_dir = 1'b0;
    test_reset();
    test_lock_timeout();
    test_lock_acquire();
    test_shift_inc();
    test_shift_dec_wrap();
    test_no_pulse();
    test_back_to_back();
    test_lock_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pll_phase_ctrl.md
Name: pll_phase_ctrl

Overview:
- Sequences the on-chip PLL that generates the 100 MHz system clock and the phase-shifted SDRAM clock.
- Responsibilities:
  - Drive the PLL reset at power-up.
  - Wait for LOCK, with timeout and retry.
  - Execute dynamic phase-shift requests by generating the PSSEL/PSDIR/PSPULSE sequence.
  - Track the current fine-phase position of each output channel.
- Runs on the 50 MHz input clock, never on a PLL output, and sits between the board clock input and the PLL primitive wrapper.

Parameters:
- NUM_CH, 7, number of PLL output channels tracked (PSSEL range 0..NUM_CH-1).
- STEPS_PER_CYC, 8, phase steps per output period; position wraps modulo this value (power of 2).
- RST_CYCLES, 16, clocks pll_reset is held high.
- LOCK_TIMEOUT, 65535, clocks waited for lock before retrying the reset.
- SETUP_CYCLES, 4, clocks pssel/psdir are stable before a pulse.
- PULSE_CYCLES, 2, width of pll_pspulse high.
- GAP_CYCLES, 4, low time between pulses.

Ports:
- clk  in  1  50 MHz reference clock, same net as the PLL input.
- rst_n  in  1  asynchronous, active-low reset.
- pll_lock  in  1  PLL LOCK, asynchronous; synchronised internally with 2 flops.
- pll_reset  out  1  PLL RESET, active high.
- pll_pssel  out  3  PLL PSSEL channel select.
- pll_psdir  out  1  PLL PSDIR; 1 = decrement (lag), 0 = increment.
- pll_pspulse  out  1  PLL PSPULSE.
- cmd_valid  in  1  phase-shift request valid.
- cmd_ready  out  1  controller can accept a request.
- cmd_ch  in  3  channel to shift.
- cmd_steps  in  4  number of steps, 0..15.
- cmd_dir  in  1  direction, same encoding as pll_psdir.
- done  out  1  one-cycle pulse when a request completes.
- locked  out  1  synchronised lock, qualified by the state machine.
- lock_lost  out  1  sticky; set on lock loss after first lock.
- ch_pos  out  NUM_CH*3  per-channel position, channel 0 in the LSBs, modulo STEPS_PER_CYC.

Behaviour:
- Reset values:
  - pll_reset=1.
  - pll_pssel=0, pll_psdir=0, pll_pspulse=0.
  - cmd_ready=0, done=0, locked=0, lock_lost=0.
  - All ch_pos=0.
- FSM states and transitions:
  - RST_HOLD: pll_reset=1 for RST_CYCLES clocks, then WAIT_LOCK.
  - WAIT_LOCK: pll_reset=0; counter runs.
    - Synced lock=1 → IDLE; locked=1.
    - Counter reaches LOCK_TIMEOUT → RST_HOLD (retry, unlimited).
  - IDLE: cmd_ready=1. Handshake on cmd_valid&cmd_ready.
    - Latch ch/steps/dir.
    - steps==0 → DONE with no pulse.
    - cmd_ch>=NUM_CH → DONE with no pulse, position unchanged.
    - Otherwise → SETUP.
  - SETUP: pssel/psdir driven from latched values for SETUP_CYCLES, then PULSE_HI.
  - PULSE_HI: pspulse=1 for PULSE_CYCLES, then PULSE_LO.
  - PULSE_LO: pspulse=0 for GAP_CYCLES.
    - On exit, update ch_pos[ch] by ±1 modulo STEPS_PER_CYC and decrement the remaining count.
    - Remaining count nonzero → PULSE_HI; otherwise → DONE.
  - DONE: done=1 for one cycle, then IDLE.
- pll_pssel/pll_psdir hold their last value outside SETUP..DONE; they are never changed while pspulse=1.
- cmd_ready is high only in IDLE. cmd_valid in any other state is ignored, with no queueing.
- Latency for N≥1 steps, handshake to done: SETUP_CYCLES + N*(PULSE_CYCLES+GAP_CYCLES) + 1 clocks.
- Lock loss: synced lock falls while in IDLE, SETUP, PULSE_HI, PULSE_LO or DONE.
  - Set lock_lost and clear locked.
  - Behaviour after that is per the optional feature.
- After any PLL reset, all ch_pos return to 0; PLL phase settings revert.
- Asynchronous reset mid-pulse: all outputs go immediately to their reset values.

Optional Feature:
- Macro PLL_AUTO_RELOCK_EN.
- Defined, on lock loss:
  - Abort any request; done is not pulsed.
  - Go to RST_HOLD and clear ch_pos.
  - lock_lost stays set until rst_n.
- Undefined, on lock loss:
  - Only lock_lost is set and locked is cleared.
  - The FSM continues; a running request completes normally.
  - The FSM leaves IDLE only via commands.
  - locked re-asserts when synced lock returns.

Decomposition:
- Package pll_ctrl_pkg holds:
  - State enum.
  - PSDIR encoding constants (DIR_INC=0, DIR_DEC=1).
  - Counter width function clog2.
- Sub-module sync2: 2-flop synchroniser with async active-low reset, used for pll_lock.
- Single shared down-counter, sized for LOCK_TIMEOUT, for all timed states.

Test Plan:
- Reset release, model asserts lock 100 clocks after pll_reset falls → pll_reset high exactly 16 clocks; locked=1 by clock 16+100+3; cmd_ready=1.
- Lock never asserted → pll_reset re-pulses every 16+65535 clocks; locked stays 0.
- Request ch=1, steps=3, dir=0 → pssel=1 stable before the first pulse; 3 pulses, each 2 high / 4 low; done at handshake+4+18+1; ch_pos[1]=3.
- Request ch=1, steps=5, dir=1 from pos 3 → wraps to 6; exactly 5 pulses; pssel/psdir never change while pspulse=1.
- steps=0 or ch=7 → done 1 cycle after handshake; no pulse; ch_pos unchanged.
- Drop lock mid-request:
  - With PLL_AUTO_RELOCK_EN: lock_lost=1, no done, RST_HOLD entered, ch_pos all 0.
  - Without it: lock_lost=1, request completes with done.
